// File: rtl/latrnq_bank_if.sv
// Bus bundle for latrnq_bank: per-channel clear/enable/data, the global
// transfer strobe, and the registered channel outputs.
interface latrnq_bank_if #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4
);
  logic [CHANNELS-1:0]       RN;
  logic [CHANNELS-1:0]       E;
  logic [CHANNELS*WIDTH-1:0] D;
  logic                      UPD;
  logic [CHANNELS*WIDTH-1:0] Q;
  logic [CHANNELS-1:0]       PEND;
  logic [CHANNELS-1:0]       CHG;

  modport master (output RN, E, D, UPD, input Q, PEND, CHG);
  modport slave  (input RN, E, D, UPD, output Q, PEND, CHG);
endinterface

// File: rtl/latrnq_bank.sv
// Bank of independent registered channels with optional shadow stage
// (MODE 0: E fills shadow, UPD transfers; MODE 1: E loads Q directly).
module latrnq_bank #(
  parameter int               WIDTH     = 4,
  parameter int               CHANNELS  = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
  parameter int               MODE      = 0
) (
  input  logic          CLK,
  input  logic          R,
  latrnq_bank_if.slave  bus
);

  logic [CHANNELS-1:0][WIDTH-1:0] q_q, q_d;
  logic [CHANNELS-1:0][WIDTH-1:0] shadow_q, shadow_d;
  logic [CHANNELS-1:0]            pend_q, pend_d;
  logic [CHANNELS-1:0]            chg_q, chg_d;
  logic [WIDTH-1:0]               din_s;

  // Next-state per channel: clear, then mode-specific load/transfer.
  always_comb begin
    q_d      = q_q;
    shadow_d = shadow_q;
    pend_d   = pend_q;
    chg_d    = {CHANNELS{1'b0}};
    din_s    = {WIDTH{1'b0}};
    for (int i = 0; i < CHANNELS; i++) begin
      din_s = bus.D[i*WIDTH +: WIDTH];
      if (!bus.RN[i]) begin
        q_d[i]      = RESET_VAL;
        shadow_d[i] = RESET_VAL;
        pend_d[i]   = 1'b0;
      end else if (MODE == 1) begin
        if (bus.E[i]) begin
          q_d[i]      = din_s;
          shadow_d[i] = din_s;
        end else begin
          q_d[i]      = q_q[i];
          shadow_d[i] = shadow_q[i];
        end
        pend_d[i] = 1'b0;
      end else begin
        // Transfer uses the pre-edge shadow, so E and UPD together pipeline.
        if (bus.UPD && pend_q[i]) begin
          q_d[i] = shadow_q[i];
        end else begin
          q_d[i] = q_q[i];
        end
        if (bus.E[i]) begin
          shadow_d[i] = din_s;
          pend_d[i]   = 1'b1;
        end else if (bus.UPD) begin
          shadow_d[i] = shadow_q[i];
          pend_d[i]   = 1'b0;
        end else begin
          shadow_d[i] = shadow_q[i];
          pend_d[i]   = pend_q[i];
        end
      end
      chg_d[i] = (q_d[i] != q_q[i]);
    end
  end

  // State registers; reset also suppresses the change flags.
  always_ff @(posedge CLK) begin
    if (R) begin
      q_q      <= {CHANNELS{RESET_VAL}};
      shadow_q <= {CHANNELS{RESET_VAL}};
      pend_q   <= {CHANNELS{1'b0}};
      chg_q    <= {CHANNELS{1'b0}};
    end else begin
      q_q      <= q_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      chg_q    <= chg_d;
    end
  end

  assign bus.Q    = q_q;
  assign bus.PEND = pend_q;
  assign bus.CHG  = chg_q;

endmodule
